// File: rtl/cache_tag_pkg.sv
// Shared widths, log2 helper and sweep/run state encoding for the cache tag tables.
package cache_tag_pkg;

  function automatic int unsigned CLOG2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  function automatic int unsigned bw_way(input int unsigned assoc);
    return CLOG2(assoc);
  endfunction

  function automatic int unsigned bw_set(input int unsigned capacity, input int unsigned assoc);
    return CLOG2(capacity / assoc);
  endfunction

  function automatic int unsigned bw_cache_addr(input int unsigned capacity,
                                                input int unsigned assoc);
    return bw_set(capacity, assoc) + bw_way(assoc);
  endfunction

  function automatic int unsigned bw_tag(input int unsigned addr_space, input int unsigned wpb,
                                         input int unsigned capacity, input int unsigned assoc);
    return addr_space - CLOG2(wpb) - bw_set(capacity, assoc);
  endfunction

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } tag_state_e;

endpackage

// File: rtl/identity_comparator.sv
// Equality compare of two equal-width words.
module identity_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             equal_c
);

  assign equal_c = (a_i == b_i);

endmodule

// File: rtl/tag_way_select.sv
// Per-set way choice: lowest matching way on a hit, else lowest invalid way, else rr_ptr.
module tag_way_select
  import cache_tag_pkg::*;
#(
  parameter int unsigned N_WAYS = 4,
  localparam int unsigned BW_WAY = CLOG2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] match_i,
  input  logic [N_WAYS-1:0] valid_i,
  input  logic [BW_WAY-1:0] rr_ptr_i,
  output logic              hit_c,
  output logic [BW_WAY-1:0] hit_way_c,
  output logic [BW_WAY-1:0] victim_way_c
);

  logic any_invalid;

  // Scan from the top so the lowest index wins.
  always_comb begin
    hit_c        = 1'b0;
    hit_way_c    = '0;
    any_invalid  = 1'b0;
    victim_way_c = rr_ptr_i;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (match_i[w]) begin
        hit_c     = 1'b1;
        hit_way_c = BW_WAY'(w);
      end
      if (!valid_i[w]) begin
        any_invalid  = 1'b1;
        victim_way_c = BW_WAY'(w);
      end
    end
    if (!any_invalid) victim_way_c = rr_ptr_i;
  end

endmodule

// File: rtl/tag_lookup_table_sa.sv
// N-way set-associative tag table with registered lookup and victim selection.
// Define TAG_LOOKUP_DIRTY_EN to store per-entry dirty bits and report them on dirty_o.
module tag_lookup_table_sa
  import cache_tag_pkg::*;
#(
  parameter int unsigned BW_ADDR_SPACE        = 16,
  parameter int unsigned CACHE_BLOCK_CAPACITY = 16,
  parameter int unsigned WORDS_PER_BLOCK      = 4,
  parameter int unsigned ASSOCIATIVITY        = 4,
  localparam int unsigned BW_WAY        = bw_way(ASSOCIATIVITY),
  localparam int unsigned BW_SET        = bw_set(CACHE_BLOCK_CAPACITY, ASSOCIATIVITY),
  localparam int unsigned BW_CACHE_ADDR = bw_cache_addr(CACHE_BLOCK_CAPACITY, ASSOCIATIVITY),
  localparam int unsigned BW_TAG        = bw_tag(BW_ADDR_SPACE, WORDS_PER_BLOCK,
                                                 CACHE_BLOCK_CAPACITY, ASSOCIATIVITY),
  localparam int unsigned BW_BLOCK      = BW_TAG + BW_SET
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  output logic                     init_busy_o,
  input  logic                     search_valid_i,
  input  logic [BW_BLOCK-1:0]      search_block_i,
  output logic                     result_valid_o,
  output logic                     hit_o,
  output logic [BW_CACHE_ADDR-1:0] addr_o,
  output logic                     dirty_o,
  input  logic                     wren_i,
  input  logic                     rmen_i,
  input  logic                     dirty_set_i,
  input  logic [BW_TAG-1:0]        tag_write_i,
  input  logic [BW_CACHE_ADDR-1:0] addr_i,
  output logic [BW_TAG-1:0]        tag_o
);

  localparam int unsigned N_SETS = CACHE_BLOCK_CAPACITY / ASSOCIATIVITY;

  logic [BW_TAG-1:0]        tag_mem [N_SETS][ASSOCIATIVITY];
  logic [ASSOCIATIVITY-1:0] valid_q [N_SETS];
  logic [BW_WAY-1:0]        rr_ptr_q [N_SETS];

  tag_state_e        state_q, state_d;
  logic [BW_SET-1:0] set_cnt_q, set_cnt_d;
  logic              init_busy_q, init_busy_d;

  logic                     result_valid_q, hit_q;
  logic [BW_CACHE_ADDR-1:0] addr_q;

  logic [BW_SET-1:0] srch_set, wr_set;
  logic [BW_TAG-1:0] srch_tag;
  logic [BW_WAY-1:0] wr_way, hit_way, victim_way, res_way;
  logic              run, search_acc, sel_hit;
  logic [ASSOCIATIVITY-1:0] tag_eq, way_valid, way_match;

  assign srch_set   = search_block_i[BW_SET-1:0];
  assign srch_tag   = search_block_i[BW_BLOCK-1:BW_SET];
  assign wr_set     = addr_i[BW_CACHE_ADDR-1:BW_WAY];
  assign wr_way     = addr_i[BW_WAY-1:0];
  assign run        = (state_q == ST_RUN);
  assign search_acc = run && search_valid_i;

  // Sweep sequencing: one set cleared per cycle, then run.
  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    init_busy_d = init_busy_q;
    if (state_q == ST_INIT) begin
      set_cnt_d   = set_cnt_q + BW_SET'(1);
      init_busy_d = 1'b1;
      if (set_cnt_q == BW_SET'(N_SETS - 1)) begin
        state_d     = ST_RUN;
        init_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_INIT;
      set_cnt_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign way_valid = valid_q[srch_set];
  assign way_match = tag_eq & way_valid;

  for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_cmp
    identity_comparator #(.WIDTH(BW_TAG)) u_cmp (
      .a_i     (tag_mem[srch_set][w]),
      .b_i     (srch_tag),
      .equal_c (tag_eq[w])
    );
  end

  tag_way_select #(.N_WAYS(ASSOCIATIVITY)) u_sel (
    .match_i      (way_match),
    .valid_i      (way_valid),
    .rr_ptr_i     (rr_ptr_q[srch_set]),
    .hit_c        (sel_hit),
    .hit_way_c    (hit_way),
    .victim_way_c (victim_way)
  );

  assign res_way = sel_hit ? hit_way : victim_way;

  // Valid bits are only cleared by the sweep; pointers reset directly.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int s = 0; s < int'(N_SETS); s++) rr_ptr_q[s] <= '0;
    end else if (state_q == ST_INIT) begin
      valid_q[set_cnt_q] <= '0;
    end else begin
      if (rmen_i)      valid_q[wr_set][wr_way] <= 1'b0;
      else if (wren_i) valid_q[wr_set][wr_way] <= 1'b1;
      if (wren_i) rr_ptr_q[wr_set] <= rr_ptr_q[wr_set] + BW_WAY'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && run && wren_i && !rmen_i) tag_mem[wr_set][wr_way] <= tag_write_i;
  end

`ifdef TAG_LOOKUP_DIRTY_EN
  logic [ASSOCIATIVITY-1:0] dirty_mem [N_SETS];
  logic                     dirty_q;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (state_q == ST_INIT)  dirty_mem[set_cnt_q] <= '0;
      else if (rmen_i)         dirty_mem[wr_set][wr_way] <= 1'b0;
      else if (wren_i)         dirty_mem[wr_set][wr_way] <= dirty_set_i;
      else if (dirty_set_i && valid_q[wr_set][wr_way])
                               dirty_mem[wr_set][wr_way] <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i)         dirty_q <= 1'b0;
    else if (search_acc) dirty_q <= dirty_mem[srch_set][res_way];
  end

  assign dirty_o = dirty_q;
`else
  logic unused_dirty_set;
  assign unused_dirty_set = dirty_set_i;
  assign dirty_o          = 1'b0;
`endif

  // Lookup result register; hit/addr hold between strobes.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      result_valid_q <= 1'b0;
      hit_q          <= 1'b0;
      addr_q         <= '0;
    end else begin
      result_valid_q <= search_acc;
      if (search_acc) begin
        hit_q  <= sel_hit;
        addr_q <= {srch_set, res_way};
      end
    end
  end

  assign init_busy_o    = init_busy_q;
  assign result_valid_o = result_valid_q;
  assign hit_o          = hit_q;
  assign addr_o         = addr_q;
  assign tag_o          = tag_mem[wr_set][wr_way];

endmodule

// File: tb/tb_tag_lookup_table_sa.sv
// Bench for tag_lookup_table_sa: directed vector table, reset-sweep sequences, random vs model.
module tb_tag_lookup_table_sa;

`ifdef TAG_LOOKUP_DIRTY_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        init_busy_o;
  logic        search_valid_i = 1'b0;
  logic [13:0] search_block_i = '0;
  logic        result_valid_o, hit_o, dirty_o;
  logic [3:0]  addr_o;
  logic        wren_i = 1'b0, rmen_i = 1'b0, dirty_set_i = 1'b0;
  logic [11:0] tag_write_i = '0;
  logic [3:0]  addr_i = '0;
  logic [11:0] tag_o;

  always #5 clk = ~clk;

  tag_lookup_table_sa #(
    .BW_ADDR_SPACE(16), .CACHE_BLOCK_CAPACITY(16), .WORDS_PER_BLOCK(4), .ASSOCIATIVITY(4)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .init_busy_o(init_busy_o),
    .search_valid_i(search_valid_i), .search_block_i(search_block_i),
    .result_valid_o(result_valid_o), .hit_o(hit_o), .addr_o(addr_o), .dirty_o(dirty_o),
    .wren_i(wren_i), .rmen_i(rmen_i), .dirty_set_i(dirty_set_i),
    .tag_write_i(tag_write_i), .addr_i(addr_i), .tag_o(tag_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 4 sets x 4 ways.
  bit          mv [4][4];
  bit          md [4][4];
  bit          mw [4][4];
  logic [11:0] mt [4][4];
  int          mrr [4];
  bit          l_hit, l_dirty;
  logic [3:0]  l_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
      end
    end
    l_hit = 1'b0; l_addr = '0; l_dirty = 1'b0;
  endtask

  function automatic void model_search(input logic [13:0] sb, output bit h,
                                       output logic [3:0] a, output bit d);
    int s = int'(sb[1:0]);
    logic [11:0] t = sb[13:2];
    int way = -1;
    for (int w = 0; w < 4; w++)
      if (way < 0 && mv[s][w] && mt[s][w] == t) way = w;
    h = (way >= 0);
    if (!h) begin
      for (int w = 0; w < 4; w++)
        if (way < 0 && !mv[s][w]) way = w;
      if (way < 0) way = mrr[s];
    end
    a = 4'(s * 4 + way);
    d = md[s][way];
  endfunction

  // One clock of stimulus; returns the model's expected outputs after the edge.
  task automatic step(input bit wr, input bit rm, input bit ds, input logic [3:0] a,
                      input logic [11:0] t, input bit sv, input logic [13:0] sb,
                      output bit ev, output bit eh, output logic [3:0] ea, output bit ed);
    int s = int'(a) / 4;
    int w = int'(a) % 4;
    bit h, d;
    logic [3:0] ra;
    wren_i = wr; rmen_i = rm; dirty_set_i = ds; addr_i = a; tag_write_i = t;
    search_valid_i = sv; search_block_i = sb;
    model_search(sb, h, ra, d);
    @(posedge clk); #1;
    if (sv) begin
      l_hit = h; l_addr = ra; l_dirty = d;
    end
    if (rm) begin
      mv[s][w] = 1'b0; md[s][w] = 1'b0;
    end else if (wr) begin
      mt[s][w] = t; mw[s][w] = 1'b1; mv[s][w] = 1'b1; md[s][w] = ds & DEN;
    end else if (ds && mv[s][w]) begin
      md[s][w] = DEN;
    end
    if (wr) mrr[s] = (mrr[s] + 1) % 4;
    ev = sv; eh = l_hit; ea = l_addr; ed = l_dirty;
    wren_i = 1'b0; rmen_i = 1'b0; dirty_set_i = 1'b0; search_valid_i = 1'b0;
  endtask

  // Count busy cycles after reset falls; a search is held high throughout.
  task automatic sweep_count(input string name);
    int c = 0;
    search_valid_i = 1'b1;
    search_block_i = {12'hABC, 2'd1};
    for (int i = 0; i < 20; i++) begin
      if (!init_busy_o) break;
      c++;
      check({name, "_no_result"}, 32'(result_valid_o), 32'd0);
      @(posedge clk); #1;
    end
    check({name, "_busy_cycles"}, 32'(c), 32'd4);
    check({name, "_no_result_end"}, 32'(result_valid_o), 32'd0);
    search_valid_i = 1'b0;
  endtask

  typedef struct {
    bit          wr, rm, ds;
    logic [3:0]  a;
    logic [11:0] t;
    bit          sv;
    logic [13:0] sb;
    bit          ev, eh;
    logic [3:0]  ea;
    bit          ed;
  } vec_t;

  vec_t vecs [26];

  initial begin
    bit ev, eh, ed;
    logic [3:0] ea;
    bit th;
    logic [3:0] ta;
    bit td;

    //        wr rm ds  a      tag      sv  block              ev eh ea    ed
    vecs[0]  = '{1, 0, 0, 4'h6, 12'hABC, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[1]  = '{0, 0, 0, 4'h0, 12'h000, 1, {12'hABC, 2'd1},   1, 1, 4'h6, 0};
    vecs[2]  = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h123, 2'd1},   1, 0, 4'h4, 0};
    vecs[3]  = '{1, 0, 0, 4'h8, 12'h200, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[4]  = '{1, 0, 0, 4'h9, 12'h201, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[5]  = '{1, 0, 0, 4'hA, 12'h202, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[6]  = '{1, 0, 0, 4'hB, 12'h203, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[7]  = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h555, 2'd2},   1, 0, 4'h8, 0};
    vecs[8]  = '{1, 0, 0, 4'h8, 12'h204, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[9]  = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h555, 2'd2},   1, 0, 4'h9, 0};
    vecs[10] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h204, 2'd2},   1, 1, 4'h8, 0};
    vecs[11] = '{1, 1, 0, 4'h3, 12'h0F0, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[12] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h0F0, 2'd0},   1, 0, 4'h0, 0};
    vecs[13] = '{1, 0, 0, 4'h1, 12'h777, 1, {12'h777, 2'd0},   1, 0, 4'h0, 0};
    vecs[14] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h777, 2'd0},   1, 1, 4'h1, 0};
    vecs[15] = '{1, 0, 1, 4'h5, 12'h111, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[16] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h111, 2'd1},   1, 1, 4'h5, DEN};
    vecs[17] = '{0, 1, 0, 4'h5, 12'h000, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[18] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h111, 2'd1},   1, 0, 4'h4, 0};
    vecs[19] = '{0, 0, 1, 4'h6, 12'h000, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[20] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'hABC, 2'd1},   1, 1, 4'h6, DEN};
    vecs[21] = '{1, 0, 1, 4'hC, 12'h300, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[22] = '{1, 0, 0, 4'hD, 12'h301, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[23] = '{1, 0, 0, 4'hE, 12'h302, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[24] = '{1, 0, 0, 4'hF, 12'h303, 0, 14'h0,             0, 0, 4'h0, 0};
    vecs[25] = '{0, 0, 0, 4'h0, 12'h000, 1, {12'h999, 2'd3},   1, 0, 4'hC, DEN};

    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 4; w++) begin
        mw[s][w] = 1'b0; mt[s][w] = '0;
      end
    model_reset();

    // Reset values and the initial sweep.
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(init_busy_o), 32'd1);
    check("rst_valid", 32'(result_valid_o), 32'd0);
    check("rst_hit", 32'(hit_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_dirty", 32'(dirty_o), 32'd0);
    reset_i = 1'b0;
    sweep_count("sweep0");

    // Directed vectors; non-search rows check that results hold.
    th = 1'b0; ta = '0; td = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step(vecs[i].wr, vecs[i].rm, vecs[i].ds, vecs[i].a, vecs[i].t, vecs[i].sv, vecs[i].sb,
           ev, eh, ea, ed);
      check($sformatf("row%0d_valid", i), 32'(result_valid_o), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        th = vecs[i].eh; ta = vecs[i].ea; td = vecs[i].ed;
      end
      check($sformatf("row%0d_hit", i), 32'(hit_o), 32'(th));
      check($sformatf("row%0d_addr", i), 32'(addr_o), 32'(ta));
      check($sformatf("row%0d_dirty", i), 32'(dirty_o), 32'(td));
    end

    // Combinational tag read.
    addr_i = 4'h8; #1;
    check("tag_read_8", 32'(tag_o), 32'h204);
    addr_i = 4'h6; #1;
    check("tag_read_6", 32'(tag_o), 32'hABC);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int op;
      bit wr, rm, ds, sv;
      logic [3:0] a;
      logic [11:0] t;
      logic [13:0] sb;
      op = int'($urandom_range(0, 3));
      wr = (op == 1); rm = (op == 2); ds = (op == 3) || (wr && $urandom_range(0, 1) == 1);
      a  = 4'($urandom_range(0, 15));
      t  = 12'($urandom_range(0, 5));
      sv = ($urandom_range(0, 3) != 0);
      sb = {12'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      step(wr, rm, ds, a, t, sv, sb, ev, eh, ea, ed);
      check($sformatf("rnd%0d_valid", i), 32'(result_valid_o), 32'(ev));
      check($sformatf("rnd%0d_hit", i), 32'(hit_o), 32'(eh));
      check($sformatf("rnd%0d_addr", i), 32'(addr_o), 32'(ea));
      check($sformatf("rnd%0d_dirty", i), 32'(dirty_o), 32'(ed));
      if (mw[int'(a) / 4][int'(a) % 4])
        check($sformatf("rnd%0d_tag", i), 32'(tag_o), 32'(mt[int'(a) / 4][int'(a) % 4]));
    end

    // Reset asserted mid-sweep restarts it; table is empty afterwards.
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midsweep_busy", 32'(init_busy_o), 32'd1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
    sweep_count("sweep1");
    step(0, 0, 0, 4'h0, 12'h0, 1, {12'hABC, 2'd1}, ev, eh, ea, ed);
    check("post_sweep_valid", 32'(result_valid_o), 32'd1);
    check("post_sweep_hit", 32'(hit_o), 32'd0);
    check("post_sweep_addr", 32'(addr_o), 32'h4);
    check("post_sweep_model_addr", 32'(addr_o), 32'(ea));
    step(0, 0, 0, 4'h0, 12'h0, 0, 14'h0, ev, eh, ea, ed);
    check("strobe_one_cycle", 32'(result_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
